// File: rtl/result_mem_writer.sv
// Writes one row-major grayscale image into the result frame memory, starting on a
// display frame boundary, and holds a level done flag once the image is complete.
module result_mem_writer #(
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 320,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              frame_done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              last_px;

  assign in_ready = (state == S_WRITE);
  assign accept   = in_valid && in_ready;
  assign last_px  = accept && (x == X_LAST) && (y == Y_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start)      state_n = S_ARM;
      S_ARM:   if (frame_done) state_n = S_WRITE;
      S_WRITE: if (last_px)    state_n = S_FLUSH;
      S_FLUSH:                 state_n = S_DONE;
      S_DONE:  if (start)      state_n = S_ARM;
      default:                 state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_ARM) || (state_n == S_WRITE) || (state_n == S_FLUSH);
      // done is dropped on ARM entry so the display never reads a half-written image
      if (state_n == S_ARM)
        done <= 1'b0;
      else if (state_n == S_DONE)
        done <= 1'b1;

      // write stage: one cycle behind acceptance
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= in_data;
      end

      // last pixel clears the counters instead of stepping past the image
      if ((state_n == S_ARM) || (state == S_DONE) || last_px) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (accept) begin
        addr <= addr + ADDR_W'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_result_mem_writer.sv
// Randomized self-checking bench for result_mem_writer on a reduced image size,
// with a scoreboard of accepted pixels and an expected-image array.
module tb_result_mem_writer;

  localparam int IMG_W  = 24;
  localparam int IMG_H  = 6;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int N      = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              frame_done;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] q[$];
  int wr_idx;
  int acc_cnt;
  int exp_mem[N];
  int dut_mem[N];

  result_mem_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_done(frame_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: the k-th accepted pixel of an image must be written to address k
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (q.size() == 0) begin
          check("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          check("wr_addr", 32'(mem_addr), 32'(wr_idx));
          check("wr_data", 32'(mem_wdata), 32'(q.pop_front()));
          if (int'(mem_addr) < N) dut_mem[mem_addr] = int'(mem_wdata);
          else check("addr_range", 32'(mem_addr), 32'(N - 1));
          wr_idx++;
        end
      end
      if (in_ready) begin
        check("x_pos", 32'(dut.x), 32'(acc_cnt % IMG_W));
        check("y_pos", 32'(dut.y), 32'(acc_cnt / IMG_W));
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        if (acc_cnt < N) exp_mem[acc_cnt] = int'(in_data);
        acc_cnt++;
      end
    end
  end

  task automatic new_image();
    q.delete();
    wr_idx  = 0;
    acc_cnt = 0;
    for (int k = 0; k < N; k++) begin
      exp_mem[k] = -1;
      dut_mem[k] = -1;
    end
  endtask

  task automatic pulse(input logic s, input logic f);
    @(posedge clk); #1;
    start = s; frame_done = f;
    @(posedge clk); #1;
    start = 1'b0; frame_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we),   32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_done"},  32'(done),     32'd0);
  endtask

  // mode 0: valid every cycle, mode 1: valid pattern 1,0,0,1, mode 2: random
  task automatic stream(input int mode, input int stop, input bit inject);
    int  c = 0;
    bit  did = 0;
    forever begin
      @(posedge clk); #1;
      if (acc_cnt >= stop) begin
        in_valid = 1'b0; start = 1'b0; frame_done = 1'b0;
        break;
      end
      if (c > N * 8) begin
        check("stream_timeout", 32'(acc_cnt), 32'(stop));
        in_valid = 1'b0; start = 1'b0; frame_done = 1'b0;
        break;
      end
      case (mode)
        0: begin in_valid = 1'b1; in_data = DATA_W'(acc_cnt); end
        1: begin in_valid = ((c % 4) == 0) || ((c % 4) == 3); in_data = DATA_W'(acc_cnt); end
        default: begin in_valid = 1'($urandom_range(0, 1)); in_data = DATA_W'($urandom); end
      endcase
      if (inject && !did && acc_cnt == 50) begin
        start = 1'b1; frame_done = 1'b1; did = 1;
      end else begin
        start = 1'b0; frame_done = 1'b0;
      end
      c++;
    end
  endtask

  task automatic finish_image(input string tag);
    @(negedge clk);
    check({tag, "_flush_done"}, 32'(done), 32'd0);
    check({tag, "_flush_busy"}, 32'(busy), 32'd1);
    check({tag, "_flush_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_writes"}, 32'(wr_idx), 32'(N));
    for (int k = 0; k < N; k++) check({tag, "_mem"}, 32'(dut_mem[k]), 32'(exp_mem[k]));
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, 32'(done), 32'd1);
    check({tag, "_idle_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_done = 1'b0; in_valid = 1'b0; in_data = '0;
    new_image();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Armed without a frame boundary: nothing may be written
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("arm_ready", 32'(in_ready), 32'd0);
      check("arm_busy",  32'(busy),     32'd1);
      check("arm_done",  32'(done),     32'd0);
    end
    pulse(1'b0, 1'b1);
    stream(0, N, 1'b0);
    finish_image("cont");

    // start with coincident frame_done: done drops, WRITE waits for the next pulse
    pulse(1'b1, 1'b1);
    @(negedge clk);
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("rearm_wait", 32'(in_ready), 32'd0);
    new_image();
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check("write_entry", 32'(in_ready), 32'd1);
    stream(1, N, 1'b0);
    finish_image("toggle");

    // Random stream with start/frame_done injected mid-image
    pulse(1'b1, 1'b0);
    new_image();
    pulse(1'b0, 1'b1);
    stream(2, N, 1'b1);
    finish_image("rand");

    // Reset mid-image, then a complete image from address 0
    pulse(1'b1, 1'b0);
    new_image();
    pulse(1'b0, 1'b1);
    stream(0, 60, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    new_image();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    stream(0, N, 1'b0);
    finish_image("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_mem_writer.md
Name: result_mem_writer

Overview:
- Upstream stage of the 480x320 VGA display path.
- Accepts a row-major 8-bit grayscale pixel stream from the processing datapath over a valid/ready handshake.
- Writes the pixels into the dual-port result frame memory through its write port.
- Starts writing only on a display frame boundary, then raises a level done flag that gates the display's readout (the Done640 input of the display stage).

Parameters:
- IMG_W, 480, pixels per row.
- IMG_H, 320, rows per image.
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load a new image.
- frame_done  in  1  one-cycle end-of-frame pulse from the display stage's DONE output.
- in_valid  in  1  pixel valid.
- in_data  in  DATA_W  pixel value.
- in_ready  out  1  block accepts a pixel this cycle.
- mem_we  out  1  write enable to the result memory.
- mem_addr  out  ADDR_W  write address, y*IMG_W+x.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  high in ARM, WRITE and FLUSH.
- done  out  1  level; image complete and valid in memory.

Behaviour:
- Reset (async assert, sync release): state=IDLE; x=0, y=0, addr=0; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
- All outputs are registered except in_ready, which is decoded from state (high only in WRITE).
- A pixel is accepted on a cycle with in_valid && in_ready.
- States:
  - IDLE: start -> ARM; done keeps its value.
  - ARM: done cleared on entry (the display stops using stale data). frame_done -> WRITE. Pixels are not accepted (in_ready=0). A frame_done in the same cycle as the start that caused the ARM entry is ignored; ARM waits for the next pulse.
  - WRITE: for each accepted pixel, the next cycle drives mem_we=1, mem_addr=addr, mem_wdata=in_data (write latency 1). Then addr+=1 and x+=1. When x==IMG_W-1, x wraps to 0 and y+=1. Acceptance of pixel y==IMG_H-1, x==IMG_W-1 -> FLUSH. in_valid low inserts bubbles: mem_we=0, counters hold.
  - FLUSH: one cycle. The final write is issued here; in_ready=0. Next state DONE.
  - DONE: done=1, busy=0. Counters reset to 0. start -> ARM (done drops the cycle after start). Otherwise stay.
- start while busy (ARM/WRITE/FLUSH) is ignored; no restart mid-image.
- frame_done outside ARM is ignored.
- addr never exceeds IMG_W*IMG_H-1. No wrap beyond the image; the last address is 153599 for defaults.
- mem_we is never high for two writes to the same address within one image.
- Reset mid-WRITE: immediate return to IDLE. Partial image is left in memory; done=0, so the display must not show it.
- Counter widths: x 9 bits, y 9 bits, addr ADDR_W bits, all unsigned.
- Throughput: 1 pixel/cycle sustained in WRITE.
- Best-case latency from the ARM->WRITE transition to done: IMG_W*IMG_H + 2 cycles.

Test Plan:
- Reset, then start with no frame_done for 1000 cycles -> in_ready=0, busy=1, mem_we never asserted, done=0.
- start, frame_done pulse, then in_valid held high with in_data=addr[7:0] -> 153600 writes at addresses 0..153599 with wdata=addr mod 256, no gaps. done rises 2 cycles after the last accepted pixel; the memory model matches.
- Same stream with in_valid toggling 1,0,0,1 -> writes occur only after accepted cycles. Addresses stay contiguous; x wraps 479->0 with y incrementing at addr 479, 959.
- start pulsed during WRITE at pixel 1000, and frame_done pulsed during WRITE -> no state change; image completes normally.
- rst_n low at pixel 5000 -> all outputs 0 asynchronously. After release, a full start/frame_done/stream sequence writes from addr 0 again.
- From DONE, start then frame_done coincident with start -> done falls next cycle; WRITE is entered only on the following frame_done.
